// File: rtl/mac_tx_arbiter.sv
// ---------------------------------------------------------------------------
// mac_tx_arbiter
//
// Round-robin scheduler that shares the single GMII transmit byte stream
// between NUM_SRC frame sources. One complete frame is granted at a time and
// streamed contiguously, since the GMII side cannot apply backpressure. A
// minimum inter-frame gap of IFG_CYCLES idle cycles is enforced. If the
// granted source underruns mid-frame, the frame is cut short on the wire and
// the rest of that frame is drained and discarded.
//
// Ports:
//   clk            transmit byte clock (125 MHz GMII domain)
//   rst            synchronous, active-high reset
//   s_tvalid       per-source byte valid
//   s_tdata        per-source byte, source i in bits [8i+7:8i]
//   s_tlast        per-source last byte of frame
//   s_tready       per-source accept, one-hot or zero
//   mac_tx_tvalid  byte valid to the GMII adapter
//   mac_tx_tdata   byte to the GMII adapter
//   mac_tx_tlast   last byte of frame
//   active_src     index of the granted source, meaningful while busy
//   busy           high while a frame is being sent or drained
//   underrun       one-cycle pulse when the granted source drops tvalid
// ---------------------------------------------------------------------------
module mac_tx_arbiter #(
    parameter int NUM_SRC    = 3,
    parameter int IFG_CYCLES = 12,
    localparam int AW        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SRC-1:0]   s_tvalid,
    input  logic [8*NUM_SRC-1:0] s_tdata,
    input  logic [NUM_SRC-1:0]   s_tlast,
    output logic [NUM_SRC-1:0]   s_tready,
    output logic                 mac_tx_tvalid,
    output logic [7:0]           mac_tx_tdata,
    output logic                 mac_tx_tlast,
    output logic [AW-1:0]        active_src,
    output logic                 busy,
    output logic                 underrun
);

    localparam int CW = (IFG_CYCLES > 2) ? $clog2(IFG_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [AW-1:0]   ptr;
    logic [AW-1:0]   grant_idx;
    logic            grant_found;
    logic [CW-1:0]   gap_cnt;
    logic            cur_valid;
    logic            cur_last;
    logic [7:0]      cur_data;

    // The granted source's current beat, used by both the FSM and the
    // output register so there is a single place that selects the lane.
    assign cur_valid = s_tvalid[active_src];
    assign cur_last  = s_tlast[active_src];
    assign cur_data  = s_tdata[8*int'(active_src) +: 8];

    // Round-robin scan: walk the request vector starting at the search
    // pointer and wrap around; the first requester found wins. This is only
    // consumed in IDLE, so the whole scan resolves in one cycle.
    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            idx = (int'(ptr) + i) % NUM_SRC;
            if (!grant_found && s_tvalid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = AW'(idx);
            end
        end
    end

    // Next-state and handshake logic. Ready is only ever offered to the
    // granted source while it is sending or being drained, so the output
    // stream can never interleave two frames. The gap counter expires on its
    // last count of 1: together with the IDLE scan cycle and the one-cycle
    // output register this yields exactly IFG_CYCLES idle cycles on the wire
    // when the next request is already waiting.
    always_comb begin
        next_state = state;
        s_tready   = '0;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    next_state = SEND;
                end
            end
            SEND: begin
                s_tready[active_src] = 1'b1;
                if (!cur_valid) begin
                    next_state = DRAIN;
                end else if (cur_last) begin
                    next_state = GAP;
                end
            end
            DRAIN: begin
                s_tready[active_src] = 1'b1;
                if (cur_valid && cur_last) begin
                    next_state = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == CW'(1)) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign busy = (state == SEND) || (state == DRAIN);

    // State register plus registered output stream. Accepted beats appear on
    // the wire one cycle later; every other cycle drives a clean all-zero
    // idle. The pointer moves only when a grant is actually made, which is
    // what keeps a continuously requesting source to one frame per round.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= '0;
            active_src    <= '0;
            gap_cnt       <= '0;
            mac_tx_tvalid <= 1'b0;
            mac_tx_tdata  <= 8'h00;
            mac_tx_tlast  <= 1'b0;
            underrun      <= 1'b0;
        end else begin
            state         <= next_state;
            mac_tx_tvalid <= (state == SEND) && cur_valid;
            mac_tx_tdata  <= ((state == SEND) && cur_valid) ? cur_data : 8'h00;
            mac_tx_tlast  <= (state == SEND) && cur_valid && cur_last;
            underrun      <= (state == SEND) && !cur_valid;

            if ((state == IDLE) && grant_found) begin
                active_src <= grant_idx;
                ptr        <= (grant_idx == AW'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
            end

            if ((state != GAP) && (next_state == GAP)) begin
                gap_cnt <= CW'(IFG_CYCLES - 1);
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mac_tx_arbiter
//
// Scoreboard bench for mac_tx_arbiter. Two instances are built: one with the
// default 12-cycle gap and one with the minimum 2-cycle gap. A select signal
// routes the shared source stimulus to one of them while the other is held
// in reset. Frames are queued per source; the expected output bytes (data,
// last flag, source index and idle cycles before the byte) are pushed in the
// order the round-robin should emit them, and a monitor pops and compares
// every valid output byte.
// ---------------------------------------------------------------------------
module tb_mac_tx_arbiter;

    localparam int NS = 3;

    typedef struct packed {
        logic       vld;
        logic [7:0] d;
        logic       l;
    } src_ent_t;

    typedef struct {
        int d;
        int l;
        int src;
        int gap;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            sel;
    logic [NS-1:0]   s_tvalid;
    logic [NS-1:0]   s_tlast;
    logic [8*NS-1:0] s_tdata;

    logic [NS-1:0]   a_tready, b_tready, m_tready;
    logic            a_valid,  b_valid,  m_valid;
    logic [7:0]      a_data,   b_data,   m_data;
    logic            a_last,   b_last,   m_last;
    logic [1:0]      a_src,    b_src,    m_src;
    logic            a_busy,   b_busy,   m_busy;
    logic            a_urun,   b_urun,   m_urun;
    logic            rst_a, rst_b;

    src_ent_t src_q [NS][$];
    exp_t     exp_q [$];

    int n_cmp    = 0;
    int n_fail   = 0;
    int idle_cnt = 1000;
    int seen     = 0;
    int urun_cnt = 0;

    assign rst_a = rst | sel;
    assign rst_b = rst | ~sel;

    assign m_tready = sel ? b_tready : a_tready;
    assign m_valid  = sel ? b_valid  : a_valid;
    assign m_data   = sel ? b_data   : a_data;
    assign m_last   = sel ? b_last   : a_last;
    assign m_src    = sel ? b_src    : a_src;
    assign m_busy   = sel ? b_busy   : a_busy;
    assign m_urun   = sel ? b_urun   : a_urun;

    mac_tx_arbiter #(.NUM_SRC(NS), .IFG_CYCLES(12)) dut_a (
        .clk           (clk),
        .rst           (rst_a),
        .s_tvalid      (s_tvalid),
        .s_tdata       (s_tdata),
        .s_tlast       (s_tlast),
        .s_tready      (a_tready),
        .mac_tx_tvalid (a_valid),
        .mac_tx_tdata  (a_data),
        .mac_tx_tlast  (a_last),
        .active_src    (a_src),
        .busy          (a_busy),
        .underrun      (a_urun)
    );

    mac_tx_arbiter #(.NUM_SRC(NS), .IFG_CYCLES(2)) dut_b (
        .clk           (clk),
        .rst           (rst_b),
        .s_tvalid      (s_tvalid),
        .s_tdata       (s_tdata),
        .s_tlast       (s_tlast),
        .s_tready      (b_tready),
        .mac_tx_tvalid (b_valid),
        .mac_tx_tdata  (b_data),
        .mac_tx_tlast  (b_last),
        .active_src    (b_src),
        .busy          (b_busy),
        .underrun      (b_urun)
    );

    // 100 MHz-style bench clock; only relative timing matters here.
    always #5 clk = ~clk;

    // Single comparison point: every check goes through here so the counts
    // in the summary line are exactly the comparisons that were made.
    task automatic check_output(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp_v, exp_v, $time);
        end
    endtask

    // Queue one frame on a source and push the bytes the wire should carry.
    // drop_at >= 0 inserts one idle source cycle before byte drop_at and one
    // more five bytes later; only the first exp_n bytes are expected out, and
    // the last flag is only expected when the whole frame reaches the wire.
    // gap is the exact idle count required before the first byte (-1 = any).
    task automatic apply_stimulus(input int src, input int nbytes, input int base,
                                  input int gap, input int exp_n, input int drop_at);
        src_ent_t e;
        exp_t     x;
        for (int k = 0; k < nbytes; k++) begin
            if (drop_at >= 0 && (k == drop_at || k == drop_at + 5)) begin
                e.vld = 1'b0;
                e.d   = 8'h00;
                e.l   = 1'b0;
                src_q[src].push_back(e);
            end
            e.vld = 1'b1;
            e.d   = 8'(base + k);
            e.l   = (k == nbytes - 1);
            src_q[src].push_back(e);
            if (k < exp_n) begin
                x.d   = (base + k) & 255;
                x.l   = (k == nbytes - 1 && exp_n == nbytes) ? 1 : 0;
                x.src = src;
                x.gap = (k == 0) ? gap : 0;
                exp_q.push_back(x);
            end
        end
    endtask

    task automatic clear_queues();
        for (int i = 0; i < NS; i++) begin
            src_q[i].delete();
        end
        exp_q.delete();
    endtask

    // Two-cycle reset of the selected instance, leaving the bench just after
    // a rising edge with empty queues.
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        clear_queues();
        urun_cnt = 0;
        rst = 1'b0;
    endtask

    // Wait, with a cycle budget, until all stimulus is consumed, every
    // expected byte has appeared and the arbiter is no longer busy.
    task automatic wait_done(input string name, input int budget);
        int  i;
        bit  done;
        done = 1'b0;
        for (i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            #3;
            if (exp_q.size() == 0 && src_q[0].size() == 0 && src_q[1].size() == 0 &&
                src_q[2].size() == 0 && !m_busy) begin
                done = 1'b1;
            end
        end
        check_output({name, "_complete"}, int'(done), 1);
        if (!done) begin
            clear_queues();
        end
        repeat (20) @(negedge clk);
    endtask

    // Source model: each falling edge presents the head of every source
    // queue. Just before the rising edge the handshake is sampled; real
    // bytes leave the queue only when accepted, idle entries always do.
    initial begin
        s_tvalid = '0;
        s_tlast  = '0;
        s_tdata  = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NS; i++) begin
                if (src_q[i].size() > 0) begin
                    s_tvalid[i]       = src_q[i][0].vld;
                    s_tlast[i]        = src_q[i][0].l & src_q[i][0].vld;
                    s_tdata[8*i +: 8] = src_q[i][0].d;
                end else begin
                    s_tvalid[i]       = 1'b0;
                    s_tlast[i]        = 1'b0;
                    s_tdata[8*i +: 8] = 8'h00;
                end
            end
            #4;
            for (int i = 0; i < NS; i++) begin
                if (src_q[i].size() > 0) begin
                    if (!src_q[i][0].vld || m_tready[i]) begin
                        void'(src_q[i].pop_front());
                    end
                end
            end
        end
    end

    // Monitor: sampled well after the rising edge. Each valid byte is
    // checked against the scoreboard head, including how many idle cycles
    // preceded it; underrun pulses are tallied for the sequence to check.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            #1;
            if (m_urun) begin
                urun_cnt++;
            end
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_byte: got data 0x%0h src %0d, expected no byte at %0t",
                             m_data, m_src, $time);
                end else begin
                    x = exp_q.pop_front();
                    check_output("data", int'(m_data), x.d);
                    check_output("tlast", int'(m_last), x.l);
                    check_output("active_src", int'(m_src), x.src);
                    if (x.gap >= 0) begin
                        check_output("idle_gap", idle_cnt, x.gap);
                    end
                end
                seen++;
                idle_cnt = 0;
            end else begin
                idle_cnt++;
            end
        end
    end

    // Directed sequence: reset state, single source with latency check,
    // round-robin, fairness, underrun, reset mid-frame, minimum gap.
    initial begin
        int seen0;
        int i;
        rst = 1'b1;
        sel = 1'b0;

        do_reset();
        check_output("rst_tvalid", int'(m_valid), 0);
        check_output("rst_tdata", int'(m_data), 0);
        check_output("rst_tlast", int'(m_last), 0);
        check_output("rst_busy", int'(m_busy), 0);
        check_output("rst_underrun", int'(m_urun), 0);
        check_output("rst_active_src", int'(m_src), 0);
        check_output("rst_tready", int'(m_tready), 0);

        $display("[TB] single source, 64 bytes from src1");
        apply_stimulus(1, 64, 8'h00, -1, 64, -1);
        @(negedge clk);
        #2;
        @(negedge clk);
        #2;
        check_output("latency_cycle1_tvalid", int'(m_valid), 0);
        check_output("latency_cycle1_busy", int'(m_busy), 1);
        @(negedge clk);
        #2;
        check_output("latency_cycle2_tvalid", int'(m_valid), 1);
        check_output("latency_cycle2_src", int'(m_src), 1);
        wait_done("single", 400);

        $display("[TB] round-robin, two 10-byte frames per source");
        do_reset();
        for (int f = 0; f < 2; f++) begin
            for (int s = 0; s < NS; s++) begin
                apply_stimulus(s, 10, 8'h40 + 16 * (f * NS + s),
                               (f == 0 && s == 0) ? -1 : 12, 10, -1);
            end
        end
        wait_done("round_robin", 600);
        check_output("rr_underrun_count", urun_cnt, 0);

        $display("[TB] fairness, src0 continuous, src2 once");
        do_reset();
        apply_stimulus(0, 8, 8'h80, -1, 8, -1);
        apply_stimulus(2, 8, 8'h90, 12, 8, -1);
        apply_stimulus(0, 8, 8'hA0, 12, 8, -1);
        apply_stimulus(0, 8, 8'hB0, 12, 8, -1);
        wait_done("fairness", 600);

        $display("[TB] underrun on src0 after 5 of 20 bytes, src1 waiting");
        do_reset();
        apply_stimulus(0, 20, 8'h20, -1, 5, 5);
        apply_stimulus(1, 10, 8'h60, 29, 10, -1);
        wait_done("underrun", 600);
        check_output("underrun_count", urun_cnt, 1);

        $display("[TB] reset at byte 30 of a 60-byte src2 frame");
        do_reset();
        seen0 = seen;
        apply_stimulus(2, 60, 8'h00, -1, 30, -1);
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            #2;
            if (seen - seen0 >= 30) break;
        end
        check_output("midreset_reached_byte30", int'(i < 200), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        clear_queues();
        rst = 1'b0;
        @(negedge clk);
        #2;
        check_output("midreset_tvalid", int'(m_valid), 0);
        check_output("midreset_tdata", int'(m_data), 0);
        check_output("midreset_busy", int'(m_busy), 0);
        check_output("midreset_tready", int'(m_tready), 0);
        @(posedge clk);
        #1;
        apply_stimulus(1, 6, 8'hC0, -1, 6, -1);
        apply_stimulus(2, 6, 8'hD0, 12, 6, -1);
        wait_done("post_reset", 400);

        $display("[TB] minimum gap instance, back-to-back 3-byte frames");
        sel = 1'b1;
        do_reset();
        apply_stimulus(0, 3, 8'hE0, -1, 3, -1);
        apply_stimulus(0, 3, 8'hE8, 2, 3, -1);
        apply_stimulus(0, 3, 8'hF0, 2, 3, -1);
        wait_done("min_gap", 200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
